// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline definitions: opcodes, privileged encodings, forwarding
// selects and interlock FSM states.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [31:0] IR_ECALL = 32'h0000_0073;
    localparam logic [31:0] IR_MRET  = 32'h3020_0073;

    // Stage slots in the per-stage decode array
    localparam int NUM_STAGES = 4;
    localparam int ST_DE      = 0;
    localparam int ST_EXE     = 1;
    localparam int ST_MEM     = 2;
    localparam int ST_WB      = 3;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BR_WAIT    = 2'd1,
        ECALL_WAIT = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic       rs1_use;
        logic [4:0] rs2;
        logic       rs2_use;
        logic [4:0] rd;
        logic       rd_wr;
        logic       is_load;
        logic       is_ctrl;
        logic       is_trap_wait;
    } reg_use_t;

    // True when producer p (valid pv) writes the register a consumer reads
    function automatic logic src_hit(input logic [4:0] src, input logic src_use,
                                     input reg_use_t p, input logic pv);
        return src_use && pv && p.rd_wr && (p.rd == src);
    endfunction

endpackage

// File: rtl/reg_use_decode.sv
// Register-use decode for one pipeline stage: source/destination fields with
// their read/write flags plus the control-class bits the interlock needs.
module reg_use_decode
    import riscv_pkg::*;
(
    input  logic [31:0] ir,
    output reg_use_t    dec
);

    logic [6:0] opc;
    logic [2:0] funct3;
    logic       rd_opc;
    logic       rs1_opc;
    logic       rs2_opc;

    assign opc    = ir[6:0];
    assign funct3 = ir[14:12];

    always_comb begin
        rd_opc  = 1'b0;
        rs1_opc = 1'b0;
        rs2_opc = 1'b0;
        unique case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: rd_opc = 1'b1;
            OPC_JALR: begin
                rd_opc  = 1'b1;
                rs1_opc = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                rs1_opc = 1'b1;
                rs2_opc = 1'b1;
            end
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32: begin
                rd_opc  = 1'b1;
                rs1_opc = 1'b1;
            end
            OPC_OP, OPC_OP_32: begin
                rd_opc  = 1'b1;
                rs1_opc = 1'b1;
                rs2_opc = 1'b1;
            end
            // CSR ops write rd; only the register forms (funct3[2]=0) read rs1
            OPC_SYSTEM: begin
                rd_opc  = (funct3 != 3'd0);
                rs1_opc = ~funct3[2];
            end
            default: ;
        endcase
    end

    always_comb begin
        dec              = '0;
        dec.rs1          = ir[19:15];
        dec.rs1_use      = rs1_opc;
        dec.rs2          = ir[24:20];
        dec.rs2_use      = rs2_opc;
        dec.rd           = ir[11:7];
        dec.rd_wr        = rd_opc && (ir[11:7] != 5'd0);
        dec.is_load      = (opc == OPC_LOAD);
        dec.is_ctrl      = (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
        dec.is_trap_wait = (ir == IR_ECALL) || (ir == IR_MRET);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage interlock: data stalls, operand forwarding selects, control
// transfer / ECALL serialisation, trap flush and a stall-cycle counter.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [31:0]            DE_IR,
    input  logic                   DE_V,
    input  logic [31:0]            EXE_IR,
    input  logic                   EXE_V,
    input  logic [31:0]            MEM_IR,
    input  logic                   MEM_V,
    input  logic [31:0]            WB_IR,
    input  logic                   WB_V,
    input  logic                   MEM_STALL,
    input  logic                   BR_RESOLVED,
    input  logic                   WB_TRAP,
    output logic                   DE_STALL,
    output logic                   DE_ISSUE_V,
    output logic [1:0]             FWD_SEL_ONE,
    output logic [1:0]             FWD_SEL_TWO,
    output logic                   V_DE_BR_STALL,
    output logic                   FLUSH,
    output logic [STALL_CNT_W-1:0] STALL_CNT
);

    logic [NUM_STAGES-1:0][31:0] stage_ir;
    reg_use_t [NUM_STAGES-1:0]   dec;

    hz_state_t              state;
    logic                   br_stall_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic     data_stall;
    logic     de_stall;
    logic     flush;
    logic     de_issue_v;
    fwd_sel_t sel_one;
    fwd_sel_t sel_two;
    logic     unused_dec;

    assign stage_ir = {WB_IR, MEM_IR, EXE_IR, DE_IR};

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_dec
        reg_use_decode u_dec (
            .ir  (stage_ir[s]),
            .dec (dec[s])
        );
    end

    // Only a subset of decode fields is consumed per stage
    assign unused_dec = ^dec;

    // EXE results are not yet available anywhere; MEM loads have no data until WB
    always_comb begin
        data_stall = 1'b0;
        if (DE_V) begin
            data_stall = src_hit(dec[ST_DE].rs1, dec[ST_DE].rs1_use, dec[ST_EXE], EXE_V)
                      || src_hit(dec[ST_DE].rs2, dec[ST_DE].rs2_use, dec[ST_EXE], EXE_V)
                      || (dec[ST_MEM].is_load &&
                          (src_hit(dec[ST_DE].rs1, dec[ST_DE].rs1_use, dec[ST_MEM], MEM_V)
                        || src_hit(dec[ST_DE].rs2, dec[ST_DE].rs2_use, dec[ST_MEM], MEM_V)));
        end
    end

    function automatic fwd_sel_t pick_src(input logic [4:0] src, input logic src_use);
        if (src_hit(src, src_use, dec[ST_MEM], MEM_V) && !dec[ST_MEM].is_load)
            return FWD_MEM;
        else if (src_hit(src, src_use, dec[ST_WB], WB_V))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        sel_one = FWD_RF;
        sel_two = FWD_RF;
        if (RESET && !data_stall) begin
            sel_one = pick_src(dec[ST_DE].rs1, dec[ST_DE].rs1_use);
            sel_two = pick_src(dec[ST_DE].rs2, dec[ST_DE].rs2_use);
        end
    end

    assign flush      = RESET && WB_TRAP;
    assign de_stall   = RESET && !flush && (data_stall || MEM_STALL);
    assign de_issue_v = RESET && DE_V && !de_stall && !MEM_STALL && !flush && (state == IDLE);

    // A trap wins over everything; MEM_STALL freezes all other transitions
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state       <= IDLE;
            br_stall_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (de_stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;

            if (WB_TRAP) begin
                state      <= IDLE;
                br_stall_q <= 1'b0;
            end else if (!MEM_STALL) begin
                unique case (state)
                    IDLE: begin
                        if (de_issue_v && dec[ST_DE].is_ctrl) begin
                            state      <= BR_WAIT;
                            br_stall_q <= 1'b1;
                        end else if (de_issue_v && dec[ST_DE].is_trap_wait) begin
                            state <= ECALL_WAIT;
                        end
                    end
                    BR_WAIT: begin
                        if (BR_RESOLVED) begin
                            state      <= IDLE;
                            br_stall_q <= 1'b0;
                        end
                    end
                    ECALL_WAIT: ;
                    default: begin
                        state      <= IDLE;
                        br_stall_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign DE_STALL      = de_stall;
    assign DE_ISSUE_V    = de_issue_v;
    assign FWD_SEL_ONE   = sel_one;
    assign FWD_SEL_TWO   = sel_two;
    assign FLUSH         = flush;
    assign V_DE_BR_STALL = RESET && br_stall_q;
    assign STALL_CNT     = RESET ? stall_cnt_q : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: interlocks, forwarding, branch/ECALL
// serialisation, trap flush, reset and stall counter saturation.
module tb_hazard_ctrl;

    localparam int CW = 4;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] ADDI_X2X1 = 32'h0010_8113;
    localparam logic [31:0] ADDI_X1   = 32'h0050_0093;
    localparam logic [31:0] ADDI_X0   = 32'h0050_0013;
    localparam logic [31:0] ADDI_X2   = 32'h0010_0113;
    localparam logic [31:0] ADD_X3    = 32'h0020_81B3;
    localparam logic [31:0] LD_X1     = 32'h0000_B083;
    localparam logic [31:0] BEQ       = 32'h0020_8463;
    localparam logic [31:0] ECALL     = 32'h0000_0073;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [31:0]   DE_IR, EXE_IR, MEM_IR, WB_IR;
    logic          DE_V, EXE_V, MEM_V, WB_V;
    logic          MEM_STALL, BR_RESOLVED, WB_TRAP;
    logic          DE_STALL, DE_ISSUE_V, V_DE_BR_STALL, FLUSH;
    logic [1:0]    FWD_SEL_ONE, FWD_SEL_TWO;
    logic [CW-1:0] STALL_CNT;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.STALL_CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET),
        .DE_IR(DE_IR), .DE_V(DE_V), .EXE_IR(EXE_IR), .EXE_V(EXE_V),
        .MEM_IR(MEM_IR), .MEM_V(MEM_V), .WB_IR(WB_IR), .WB_V(WB_V),
        .MEM_STALL(MEM_STALL), .BR_RESOLVED(BR_RESOLVED), .WB_TRAP(WB_TRAP),
        .DE_STALL(DE_STALL), .DE_ISSUE_V(DE_ISSUE_V),
        .FWD_SEL_ONE(FWD_SEL_ONE), .FWD_SEL_TWO(FWD_SEL_TWO),
        .V_DE_BR_STALL(V_DE_BR_STALL), .FLUSH(FLUSH), .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        DE_IR = NOP; EXE_IR = NOP; MEM_IR = NOP; WB_IR = NOP;
        DE_V = 0; EXE_V = 0; MEM_V = 0; WB_V = 0;
        MEM_STALL = 0; BR_RESOLVED = 0; WB_TRAP = 0;
    endtask

    // Advance past the next rising edge, then leave room for new inputs
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        RESET = 0;
        DE_IR = BEQ; DE_V = 1; WB_TRAP = 1; MEM_STALL = 1;
        EXE_IR = ADDI_X1; EXE_V = 1; MEM_IR = ADDI_X1; MEM_V = 1;
        tick(); #1;
        total++; if (DE_STALL !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", DE_STALL); end
        total++; if (DE_ISSUE_V !== 1'b0) begin bad++; $display("FAIL reset_issue got=%b exp=0", DE_ISSUE_V); end
        total++; if (FLUSH !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", FLUSH); end
        total++; if ({FWD_SEL_ONE, FWD_SEL_TWO} !== 4'b0) begin bad++; $display("FAIL reset_fwd got=%b exp=0000", {FWD_SEL_ONE, FWD_SEL_TWO}); end
        clear_inputs();
        RESET = 1;
        #1;
        total++; if (STALL_CNT !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", STALL_CNT); end
        total++; if (V_DE_BR_STALL !== 1'b0) begin bad++; $display("FAIL reset_brstall got=%b exp=0", V_DE_BR_STALL); end
    endtask

    task automatic test_raw_exe();
        clear_inputs();
        DE_IR = ADDI_X2X1; DE_V = 1; EXE_IR = ADDI_X1; EXE_V = 1;
        #1;
        total++; if (DE_STALL !== 1'b1) begin bad++; $display("FAIL raw_exe_stall got=%b exp=1", DE_STALL); end
        total++; if (DE_ISSUE_V !== 1'b0) begin bad++; $display("FAIL raw_exe_issue got=%b exp=0", DE_ISSUE_V); end
        tick();
        EXE_V = 0; MEM_IR = ADDI_X1; MEM_V = 1;
        #1;
        total++; if (FWD_SEL_ONE !== 2'b01) begin bad++; $display("FAIL raw_mem_fwd got=%b exp=01", FWD_SEL_ONE); end
        total++; if (DE_ISSUE_V !== 1'b1) begin bad++; $display("FAIL raw_mem_issue got=%b exp=1", DE_ISSUE_V); end
        total++; if (STALL_CNT !== 4'd1) begin bad++; $display("FAIL raw_mem_cnt got=%0d exp=1", STALL_CNT); end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        DE_IR = ADDI_X2X1; DE_V = 1; EXE_IR = LD_X1; EXE_V = 1;
        #1;
        total++; if (DE_STALL !== 1'b1) begin bad++; $display("FAIL ld_exe_stall got=%b exp=1", DE_STALL); end
        tick();
        EXE_V = 0; MEM_IR = LD_X1; MEM_V = 1;
        #1;
        total++; if (DE_STALL !== 1'b1) begin bad++; $display("FAIL ld_mem_stall got=%b exp=1", DE_STALL); end
        total++; if (DE_ISSUE_V !== 1'b0) begin bad++; $display("FAIL ld_mem_issue got=%b exp=0", DE_ISSUE_V); end
        tick();
        MEM_V = 0; WB_IR = LD_X1; WB_V = 1;
        #1;
        total++; if (FWD_SEL_ONE !== 2'b10) begin bad++; $display("FAIL ld_wb_fwd got=%b exp=10", FWD_SEL_ONE); end
        total++; if (DE_STALL !== 1'b0) begin bad++; $display("FAIL ld_wb_stall got=%b exp=0", DE_STALL); end
        total++; if (STALL_CNT !== 4'd3) begin bad++; $display("FAIL ld_wb_cnt got=%0d exp=3", STALL_CNT); end
        tick();
    endtask

    task automatic test_fwd_patterns();
        clear_inputs();
        DE_IR = NOP; DE_V = 1; EXE_IR = ADDI_X0; EXE_V = 1; MEM_IR = ADDI_X0; MEM_V = 1;
        #1;
        total++; if (DE_STALL !== 1'b0) begin bad++; $display("FAIL x0_stall got=%b exp=0", DE_STALL); end
        total++; if ({FWD_SEL_ONE, FWD_SEL_TWO} !== 4'b0000) begin bad++; $display("FAIL x0_fwd got=%b exp=0000", {FWD_SEL_ONE, FWD_SEL_TWO}); end
        // invalid producer in EXE is ignored; rs1 from MEM, rs2 from WB
        DE_IR = ADD_X3; EXE_IR = ADDI_X2; EXE_V = 0;
        MEM_IR = ADDI_X1; MEM_V = 1; WB_IR = ADDI_X2; WB_V = 1;
        #1;
        total++; if (DE_STALL !== 1'b0) begin bad++; $display("FAIL mix_stall got=%b exp=0", DE_STALL); end
        total++; if ({FWD_SEL_ONE, FWD_SEL_TWO} !== 4'b0110) begin bad++; $display("FAIL mix_fwd got=%b exp=0110", {FWD_SEL_ONE, FWD_SEL_TWO}); end
        WB_IR = ADDI_X1;
        #1;
        total++; if (FWD_SEL_ONE !== 2'b01) begin bad++; $display("FAIL prio_fwd got=%b exp=01", FWD_SEL_ONE); end
        EXE_V = 1;
        #1;
        total++; if (DE_STALL !== 1'b1) begin bad++; $display("FAIL rs2_exe_stall got=%b exp=1", DE_STALL); end
        clear_inputs();
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        DE_IR = BEQ; DE_V = 1;
        #1;
        total++; if (DE_ISSUE_V !== 1'b1) begin bad++; $display("FAIL br_issue got=%b exp=1", DE_ISSUE_V); end
        total++; if (V_DE_BR_STALL !== 1'b0) begin bad++; $display("FAIL br_pre_stall got=%b exp=0", V_DE_BR_STALL); end
        tick();
        DE_IR = NOP;
        #1;
        total++; if (V_DE_BR_STALL !== 1'b1) begin bad++; $display("FAIL br_wait_flag got=%b exp=1", V_DE_BR_STALL); end
        total++; if (DE_ISSUE_V !== 1'b0) begin bad++; $display("FAIL br_wait_issue got=%b exp=0", DE_ISSUE_V); end
        total++; if (DE_STALL !== 1'b0) begin bad++; $display("FAIL br_wait_destall got=%b exp=0", DE_STALL); end
        tick();
        BR_RESOLVED = 1;
        #1;
        total++; if (DE_ISSUE_V !== 1'b0) begin bad++; $display("FAIL br_res_issue got=%b exp=0", DE_ISSUE_V); end
        tick();
        BR_RESOLVED = 0;
        #1;
        total++; if (V_DE_BR_STALL !== 1'b0) begin bad++; $display("FAIL br_idle_flag got=%b exp=0", V_DE_BR_STALL); end
        total++; if (DE_ISSUE_V !== 1'b1) begin bad++; $display("FAIL br_idle_issue got=%b exp=1", DE_ISSUE_V); end
        tick();
    endtask

    task automatic test_ecall();
        clear_inputs();
        DE_IR = ECALL; DE_V = 1;
        #1;
        total++; if (DE_ISSUE_V !== 1'b1) begin bad++; $display("FAIL ecall_issue got=%b exp=1", DE_ISSUE_V); end
        tick();
        DE_IR = NOP;
        #1;
        total++; if (DE_ISSUE_V !== 1'b0) begin bad++; $display("FAIL ecall_wait_issue got=%b exp=0", DE_ISSUE_V); end
        total++; if (V_DE_BR_STALL !== 1'b0) begin bad++; $display("FAIL ecall_wait_flag got=%b exp=0", V_DE_BR_STALL); end
        tick();
        WB_TRAP = 1; DE_IR = ADDI_X2X1; EXE_IR = ADDI_X1; EXE_V = 1;
        #1;
        total++; if (FLUSH !== 1'b1) begin bad++; $display("FAIL trap_flush got=%b exp=1", FLUSH); end
        total++; if (DE_STALL !== 1'b0) begin bad++; $display("FAIL trap_destall got=%b exp=0", DE_STALL); end
        total++; if (DE_ISSUE_V !== 1'b0) begin bad++; $display("FAIL trap_issue got=%b exp=0", DE_ISSUE_V); end
        tick();
        WB_TRAP = 0; DE_IR = NOP; EXE_V = 0;
        #1;
        total++; if (FLUSH !== 1'b0) begin bad++; $display("FAIL post_trap_flush got=%b exp=0", FLUSH); end
        total++; if (DE_ISSUE_V !== 1'b1) begin bad++; $display("FAIL post_trap_issue got=%b exp=1", DE_ISSUE_V); end
        tick();
    endtask

    task automatic test_trap_coincide();
        clear_inputs();
        DE_IR = BEQ; DE_V = 1; WB_TRAP = 1;
        #1;
        total++; if (DE_ISSUE_V !== 1'b0) begin bad++; $display("FAIL coin_issue got=%b exp=0", DE_ISSUE_V); end
        tick();
        WB_TRAP = 0; DE_IR = NOP;
        #1;
        total++; if (V_DE_BR_STALL !== 1'b0) begin bad++; $display("FAIL coin_idle got=%b exp=0", V_DE_BR_STALL); end
        DE_IR = BEQ;
        tick();
        DE_IR = NOP; BR_RESOLVED = 1; WB_TRAP = 1;
        #1;
        total++; if (FLUSH !== 1'b1) begin bad++; $display("FAIL res_trap_flush got=%b exp=1", FLUSH); end
        tick();
        clear_inputs(); DE_V = 1;
        #1;
        total++; if (V_DE_BR_STALL !== 1'b0) begin bad++; $display("FAIL res_trap_idle got=%b exp=0", V_DE_BR_STALL); end
        total++; if (DE_ISSUE_V !== 1'b1) begin bad++; $display("FAIL res_trap_issue got=%b exp=1", DE_ISSUE_V); end
        tick();
    endtask

    task automatic test_reset_mid_branch();
        clear_inputs();
        RESET = 0;
        tick();
        RESET = 1; MEM_STALL = 1;
        #1;
        total++; if (DE_STALL !== 1'b1) begin bad++; $display("FAIL memstall_destall got=%b exp=1", DE_STALL); end
        repeat (7) tick();
        MEM_STALL = 0; DE_IR = BEQ; DE_V = 1;
        tick();
        DE_IR = NOP;
        #1;
        total++; if (STALL_CNT !== 4'd7) begin bad++; $display("FAIL pre_rst_cnt got=%0d exp=7", STALL_CNT); end
        total++; if (V_DE_BR_STALL !== 1'b1) begin bad++; $display("FAIL pre_rst_flag got=%b exp=1", V_DE_BR_STALL); end
        RESET = 0;
        #1;
        total++; if ({V_DE_BR_STALL, DE_ISSUE_V, DE_STALL, FLUSH} !== 4'b0) begin bad++; $display("FAIL mid_rst_outs got=%b exp=0000", {V_DE_BR_STALL, DE_ISSUE_V, DE_STALL, FLUSH}); end
        total++; if (STALL_CNT !== 4'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", STALL_CNT); end
        tick();
        RESET = 1;
        #1;
        total++; if (V_DE_BR_STALL !== 1'b0) begin bad++; $display("FAIL post_rst_flag got=%b exp=0", V_DE_BR_STALL); end
        total++; if (DE_ISSUE_V !== 1'b1) begin bad++; $display("FAIL post_rst_issue got=%b exp=1", DE_ISSUE_V); end
        // frozen pipe: a branch in DE neither issues nor moves the FSM
        DE_IR = BEQ; MEM_STALL = 1;
        #1;
        total++; if (DE_ISSUE_V !== 1'b0) begin bad++; $display("FAIL frz_issue got=%b exp=0", DE_ISSUE_V); end
        tick();
        MEM_STALL = 0; DE_IR = NOP;
        #1;
        total++; if (V_DE_BR_STALL !== 1'b0) begin bad++; $display("FAIL frz_hold_idle got=%b exp=0", V_DE_BR_STALL); end
        total++; if (STALL_CNT !== 4'd1) begin bad++; $display("FAIL frz_cnt got=%0d exp=1", STALL_CNT); end
        DE_IR = BEQ;
        tick();
        DE_IR = NOP; MEM_STALL = 1; BR_RESOLVED = 1;
        tick();
        MEM_STALL = 0; BR_RESOLVED = 0;
        #1;
        total++; if (V_DE_BR_STALL !== 1'b1) begin bad++; $display("FAIL frz_hold_br got=%b exp=1", V_DE_BR_STALL); end
        BR_RESOLVED = 1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_saturate();
        clear_inputs();
        RESET = 0;
        tick();
        RESET = 1; MEM_STALL = 1;
        repeat (20) tick();
        MEM_STALL = 0;
        #1;
        total++; if (STALL_CNT !== 4'hF) begin bad++; $display("FAIL sat_cnt got=%0d exp=15", STALL_CNT); end
        tick();
    endtask

    initial begin
        clear_inputs();
        RESET = 0;
        test_reset();
        test_raw_exe();
        test_load_use();
        test_fwd_patterns();
        test_branch();
        test_ecall();
        test_trap_coincide();
        test_reset_mid_branch();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
